clk_divider_prog: RTL
=====================

CLK_DIVIDER_PROG -- requirements
Module: clk_divider_prog

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning width of divisor and period counter.
REQ-002 SHALL have parameter DIV_RST, default 10, meaning divisor in effect after reset (2 <= DIV_RST <= 2^CNT_W-1).
REQ-003 SHALL have port clk  input  1  sole clock; all flops on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  run request; level-sensitive.
REQ-006 SHALL have port div_val  input  CNT_W  requested divisor N.
REQ-007 SHALL have port div_load  input  1  one-cycle strobe capturing div_val.
REQ-008 SHALL have port err_clr  input  1  clears cfg_err.
REQ-009 SHALL have port clk_div  output  1  divided clock, driven directly by a flop.
REQ-010 SHALL have port tick_rise  output  1  one-cycle pulse, coincident with each clk_div low-to-high transition.
REQ-011 SHALL have port tick_fall  output  1  one-cycle pulse, coincident with each clk_div high-to-low transition.
REQ-012 SHALL have port busy  output  1  high in RUN or STOP_PEND.
REQ-013 SHALL have port cur_div  output  CNT_W  divisor currently in effect.
REQ-014 SHALL have port cfg_err  output  1  sticky flag set when an illegal divisor is loaded.

Function
REQ-015 SHALL implement states IDLE, RUN and STOP_PEND.
REQ-016 SHALL maintain period counter cnt in range 0..N-1, incrementing by 1 per clk in RUN/STOP_PEND and wrapping from N-1 to 0.
REQ-017 SHALL define high time H = (N+1)>>1 and low time N-H; for N=2 this gives 1/1, for N=5 3/2, for N=10 5/5.
REQ-018 SHALL hold clk_div=1 exactly in cycles where busy=1 and cnt<H; otherwise clk_div=0.
REQ-019 SHALL assert tick_rise in every busy cycle with cnt==0, and tick_fall in the cycle after the last high cycle (cnt==H), including the cycle entering IDLE.
REQ-020 IDLE->RUN: with en=1 sampled in IDLE, the next cycle SHALL have cnt=0, clk_div=1 and tick_rise=1 (1-cycle latency).
REQ-021 RUN->STOP_PEND: with en=0 sampled in RUN, the current period SHALL complete unchanged.
REQ-022 STOP_PEND->RUN: with en=1 sampled before wrap, the state SHALL return to RUN with no disturbance to cnt or clk_div.
REQ-023 STOP_PEND->IDLE: at wrap (cnt==N-1), the block SHALL enter IDLE with clk_div=0 and cnt=0; it SHALL never truncate a period.
REQ-024 div_load SHALL capture div_val into a pending register and set a pending flag; a later load before application SHALL overwrite the pending value.
REQ-025 In IDLE, a pending divisor SHALL be applied on the next cycle.
REQ-026 In RUN/STOP_PEND, a pending divisor SHALL be applied only at wrap, so the period starting at cnt=0 uses the new N and no partial period occurs.
REQ-027 A div_load coinciding with wrap SHALL be applied at that wrap.
REQ-028 A div_load coinciding with the IDLE->RUN transition SHALL give the first period the new N.
REQ-029 A loaded div_val of 0 or 1 SHALL be replaced by 2 and SHALL set cfg_err on the following cycle.
REQ-030 cfg_err SHALL remain set until err_clr=1 or rst=1; if err_clr and an illegal load occur in the same cycle, set wins.
REQ-031 cur_div SHALL change only when a divisor is applied, and SHALL always reflect the N governing the current period.
REQ-032 Counter compares SHALL be CNT_W bits wide and unsigned; N=2^CNT_W-1 SHALL work without overflow.

Reset
REQ-033 With rst=1 at a clk edge, the next cycle SHALL give state=IDLE, cnt=0, clk_div=0, tick_rise=0, tick_fall=0, busy=0, cfg_err=0, pending flag=0, cur_div=DIV_RST.
REQ-034 rst SHALL take priority over en, div_load and err_clr, and SHALL abort any period mid-operation with no completion.

Verification
REQ-035 Bench SHALL check: reset, en=1 held, N=10 -> clk_div 5 high/5 low; tick_rise every 10 clk; first tick_rise 1 cycle after en.
REQ-036 Bench SHALL check: N=5 running, div_load div_val=3 at cnt=1 -> current period stays 3H/2L; next period 2H/1L; cur_div changes 5->3 at wrap.
REQ-037 Bench SHALL check: N=4 running, en dropped at cnt=0 -> full 2H/2L period completes, then IDLE with busy=0; a re-assert at cnt=2 gives uninterrupted periods.
REQ-038 Bench SHALL check: div_load div_val=1 -> cur_div=2, cfg_err=1 stays set; err_clr -> 0; simultaneous err_clr with illegal load -> cfg_err stays 1.
REQ-039 Bench SHALL check: rst=1 pulsed at cnt=3 of N=8 -> next cycle clk_div=0, busy=0, cur_div=DIV_RST; restart gives clean period.
REQ-040 Bench SHALL check: CNT_W=4, N=15 -> 8H/7L, wrap 14->0 correct; N=2 -> clk_div toggles every clk.

Source files
------------

// File: rtl/clk_divider_prog.sv
// -----------------------------------------------------------------------------
// clk_divider_prog
//
// Programmable clock divider. It produces a flop-driven divided clock with a
// run/stop handshake that never truncates a period. The divisor can be changed
// on the fly: a new divisor only takes effect at a period boundary.
//
// Each period of divisor N is H = (N+1)>>1 cycles high, then N-H cycles low.
// When en is dropped, the block finishes the current period and then stops.
//
// Parameters
//   CNT_W    width of the divisor and the period counter
//   DIV_RST  divisor in effect after reset (2 .. 2^CNT_W-1)
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset; overrides every other input
//   en         in   run request (level)
//   div_val    in   requested divisor N
//   div_load   in   one-cycle strobe that captures div_val as the pending divisor
//   err_clr    in   clears cfg_err
//   clk_div    out  divided clock, driven directly by a flop
//   tick_rise  out  one-cycle pulse in the first high cycle of each period
//   tick_fall  out  one-cycle pulse in the first cycle after the high phase
//   busy       out  high while RUN or STOP_PEND
//   cur_div    out  divisor governing the current period
//   cfg_err    out  sticky flag: a divisor of 0 or 1 was loaded (replaced by 2)
//   dbg_state  out  FSM state encoding (0 IDLE, 1 RUN, 2 STOP_PEND)
//
// Handshake: div_load is a single-cycle strobe with no ready. A load always
// lands in the pending register. A second load before the divisor is applied
// simply overwrites the pending value.
// -----------------------------------------------------------------------------
module clk_divider_prog #(
    parameter int CNT_W   = 8,
    parameter int DIV_RST = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    input  logic             err_clr,
    output logic             clk_div,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic             busy,
    output logic [CNT_W-1:0] cur_div,
    output logic             cfg_err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RUN       = 2'd1,
        S_STOP_PEND = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_div;
    logic [CNT_W-1:0]   r_pend_val;
    logic               r_pend;
    logic               r_cfg_err;
    logic               r_clk_div;
    logic               r_tick_rise;
    logic               r_tick_fall;

    state_t             w_state_n;
    logic [CNT_W-1:0]   w_cnt_n;
    logic [CNT_W-1:0]   w_div_n;
    logic [CNT_W-1:0]   w_high_n;
    logic [CNT_W-1:0]   w_next_div;
    logic [CNT_W-1:0]   w_load_val;
    logic               w_load_bad;
    logic               w_wrap;
    logic               w_apply;
    logic               w_busy_n;
    logic               w_clk_n;

    // Illegal divisors are replaced by 2, the smallest period that still toggles.
    assign w_load_bad = (div_val < CNT_W'(2));
    assign w_load_val = w_load_bad ? CNT_W'(2) : div_val;

    // r_div is always >= 2, so the subtraction cannot underflow.
    assign w_wrap = (r_cnt == (r_div - CNT_W'(1)));

    // A load in the same cycle as the application point wins over the older
    // pending value.
    assign w_next_div = div_load ? w_load_val : (r_pend ? r_pend_val : r_div);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_apply   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The divisor may change freely while idle.
                w_cnt_n = '0;
                w_apply = 1'b1;
                if (en) begin
                    w_state_n = S_RUN;
                end
            end
            S_RUN: begin
                w_cnt_n = w_wrap ? '0 : r_cnt + CNT_W'(1);
                w_apply = w_wrap;
                if (!en) begin
                    w_state_n = w_wrap ? S_IDLE : S_STOP_PEND;
                end
            end
            S_STOP_PEND: begin
                w_cnt_n = w_wrap ? '0 : r_cnt + CNT_W'(1);
                w_apply = w_wrap;
                if (en) begin
                    w_state_n = S_RUN;
                end else if (w_wrap) begin
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
            end
        endcase
        w_div_n = w_apply ? w_next_div : r_div;
    end

    // High time computed as N/2 + N[0]. This equals (N+1)>>1 and cannot
    // overflow at N = 2^CNT_W-1.
    assign w_high_n = (w_div_n >> 1) + {{(CNT_W-1){1'b0}}, w_div_n[0]};
    assign w_busy_n = (w_state_n != S_IDLE);
    assign w_clk_n  = w_busy_n && (w_cnt_n < w_high_n);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_div       <= CNT_W'(DIV_RST);
            r_pend_val  <= '0;
            r_pend      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_clk_div   <= 1'b0;
            r_tick_rise <= 1'b0;
            r_tick_fall <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_div       <= w_div_n;
            r_clk_div   <= w_clk_n;
            r_tick_rise <= w_busy_n && (w_cnt_n == '0);
            r_tick_fall <= r_clk_div && !w_clk_n;
            if (div_load) begin
                r_pend_val <= w_load_val;
            end
            if (w_apply) begin
                r_pend <= 1'b0;
            end else if (div_load) begin
                r_pend <= 1'b1;
            end
            // If an illegal load and a clear arrive together, the set wins.
            if (div_load && w_load_bad) begin
                r_cfg_err <= 1'b1;
            end else if (err_clr) begin
                r_cfg_err <= 1'b0;
            end
        end
    end

    assign clk_div   = r_clk_div;
    assign tick_rise = r_tick_rise;
    assign tick_fall = r_tick_fall;
    assign busy      = (r_state != S_IDLE);
    assign cur_div   = r_div;
    assign cfg_err   = r_cfg_err;
    assign dbg_state = r_state;

endmodule
